multi_hex_display: RTL

MULTI_HEX_DISPLAY -- requirements
Module: multi_hex_display

---
 rtl/multi_hex_display.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/multi_hex_display.sv
// Multi-digit hex display driver.
//
// Latches DIGITS hex nibbles plus decimal points on `load`. It presents them two ways:
// - as static active-low 7-segment codes on hex_out;
// - as a registered, time-multiplexed scan on seg_mux/an.
//
// Optional leading-zero blanking (blank_lz) is sampled live.
//
// Define HEX_BLINK_EN to add a blink counter. Digits selected by blink_mask are then
// blanked while the blink phase is high. Without the macro, blink_mask is accepted and
// ignored.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   value      hex nibbles, digit i = value[4i+3:4i]
//   dp         per-digit decimal point request (active-high)
//   load       latch value/dp
//   blank_lz   leading-zero blanking enable
//   blink_mask per-digit blink enable
//   hex_out    static active-low segments, digit i = hex_out[8i+7:8i]
//   seg_mux    active-low segments of the scanned digit (registered)
//   an         one-hot active-low digit select (registered)
module multi_hex_display #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [8*DIGITS-1:0]   hex_out,
  output logic [7:0]            seg_mux,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]  IdxMax  = IdxW'(DIGITS - 1);

  logic [4*DIGITS-1:0] val_q;
  logic [DIGITS-1:0]   dp_q;
  logic [ScanW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]     scan_idx_q, scan_idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   lz_blank;
  logic [DIGITS-1:0]   blink_blank;
  logic                upper_zero;

  // Active-high g..a pattern for one nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    seg_decode = 7'h00;
    case (nib)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      4'hF: seg_decode = 7'h71;
    endcase
  endfunction

  // Walk down from the top digit. A digit is a leading zero while it and everything
  // above it is zero. Digit 0 always shows.
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero & (val_q[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz & upper_zero & (i != 0);
    end
  end

`ifdef HEX_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BlinkW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BlinkMax) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_blank = blink_phase_q ? blink_mask : '0;
`else
  logic        unused_blink_mask;
  logic [31:0] unused_blink_div;
  assign unused_blink_mask = ^blink_mask;
  assign unused_blink_div  = BLINK_DIV;
  assign blink_blank       = '0;
`endif

  always_comb begin
    hex_out = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (lz_blank[i] || blink_blank[i]) begin
        hex_out[8*i +: 8] = 8'hFF;
      end else begin
        hex_out[8*i +: 8] = {~dp_q[i], ~seg_decode(val_q[4*i +: 4])};
      end
    end
  end

  // Scan timing; with DIGITS=1, IdxMax is 0 so the index never leaves 0.
  always_comb begin
    scan_cnt_d = scan_cnt_q + ScanW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == ScanMax) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IdxMax) ? '0 : scan_idx_q + IdxW'(1);
    end
  end

  // Mux outputs track the index being entered, so an/seg_mux change on the same edge
  // as scan_idx.
  always_comb begin
    seg_d = 8'hFF;
    an_d  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IdxW'(i) == scan_idx_d) begin
        seg_d = hex_out[8*i +: 8];
        an_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q      <= '0;
      dp_q       <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      an_q       <= ~DIGITS'(1);
      seg_q      <= 8'hC0;
    end else begin
      if (load) begin
        val_q <= value;
        dp_q  <= dp;
      end
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign seg_mux = seg_q;
  assign an      = an_q;

endmodule
